// File: rtl/sram_bist_if.sv
// Functional and SRAM-side buses of the March C- BIST multiplexer.
// slave: seen by sram_bist; master: seen by the surrounding logic and the SRAM wrapper.
interface sram_bist_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
);
   logic              f_mem_en_i;
   logic              f_w_en_i;
   logic              f_r_en_i;
   logic [ADDR_W-1:0] f_w_addr_i;
   logic [ADDR_W-1:0] f_r_addr_i;
   logic [DATA_W-1:0] f_w_data_i;
   logic [DATA_W-1:0] f_r_data_o;

   logic              m_mem_en_o;
   logic              m_w_en_o;
   logic              m_r_en_o;
   logic [ADDR_W-1:0] m_w_addr_o;
   logic [ADDR_W-1:0] m_r_addr_o;
   logic [DATA_W-1:0] m_w_data_o;
   logic [DATA_W-1:0] m_r_data_i;

   modport slave (
      input  f_mem_en_i, f_w_en_i, f_r_en_i, f_w_addr_i, f_r_addr_i, f_w_data_i,
      output f_r_data_o,
      output m_mem_en_o, m_w_en_o, m_r_en_o, m_w_addr_o, m_r_addr_o, m_w_data_o,
      input  m_r_data_i
   );

   modport master (
      output f_mem_en_i, f_w_en_i, f_r_en_i, f_w_addr_i, f_r_addr_i, f_w_data_i,
      input  f_r_data_o,
      input  m_mem_en_o, m_w_en_o, m_r_en_o, m_w_addr_o, m_r_addr_o, m_w_data_o,
      output m_r_data_i
   );
endinterface

// File: rtl/sram_bist.sv
// March C- BIST controller and functional/BIST port multiplexer for sram_256x8.
// Optional first-failure log enabled by defining SRAM_BIST_FAIL_LOG_EN.
module sram_bist #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              bist_start_i,
   output logic              bist_busy_o,
   output logic              bist_done_o,
   output logic              bist_pass_o,
   sram_bist_if.slave        bus
`ifdef SRAM_BIST_FAIL_LOG_EN
   ,
   output logic [ADDR_W-1:0] fail_addr_o,
   output logic [DATA_W-1:0] fail_exp_o,
   output logic [DATA_W-1:0] fail_got_o
`endif
);
   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
   localparam logic [DATA_W-1:0] ZEROS    = '0;
   localparam logic [DATA_W-1:0] ONES     = '1;

   state_t            state;
   logic [2:0]        elem;      // March element M0..M5
   logic [ADDR_W-1:0] addr;
   logic              second;    // write half of a read-then-write address
   logic              pass_q;
   logic              cmp_pend;
   logic [DATA_W-1:0] cmp_exp;

   logic              op_read;
   logic              op_last;
   logic              desc;
   logic              addr_end;
   logic              mismatch;
   logic [DATA_W-1:0] exp_data;
   logic [DATA_W-1:0] wr_data;

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
   always_comb begin
      op_read  = 1'b0;
      op_last  = 1'b1;
      exp_data = ZEROS;
      wr_data  = ZEROS;
      case (elem)
         3'd0: wr_data = ZEROS;
         3'd1: begin op_read = !second; op_last = second; exp_data = ZEROS; wr_data = ONES;  end
         3'd2: begin op_read = !second; op_last = second; exp_data = ONES;  wr_data = ZEROS; end
         3'd3: begin op_read = !second; op_last = second; exp_data = ZEROS; wr_data = ONES;  end
         3'd4: begin op_read = !second; op_last = second; exp_data = ONES;  wr_data = ZEROS; end
         default: begin op_read = 1'b1; exp_data = ZEROS; end
      endcase
      desc     = (elem == 3'd3) || (elem == 3'd4);
      addr_end = desc ? (addr == '0) : (addr == ADDR_MAX);
      mismatch = cmp_pend && (bus.m_r_data_i != cmp_exp);
   end

   // BIST owns the SRAM through RUN and DRAIN; otherwise the functional port passes straight through.
   always_comb begin
      bus.m_mem_en_o = bus.f_mem_en_i;
      bus.m_w_en_o   = bus.f_w_en_i;
      bus.m_r_en_o   = bus.f_r_en_i;
      bus.m_w_addr_o = bus.f_w_addr_i;
      bus.m_r_addr_o = bus.f_r_addr_i;
      bus.m_w_data_o = bus.f_w_data_i;
      if (state == RUN || state == DRAIN) begin
         bus.m_mem_en_o = (state == RUN);
         bus.m_w_en_o   = (state == RUN) && !op_read;
         bus.m_r_en_o   = (state == RUN) && op_read;
         bus.m_w_addr_o = addr;
         bus.m_r_addr_o = addr;
         bus.m_w_data_o = wr_data;
      end
   end

   assign bus.f_r_data_o = bus.m_r_data_i;
   assign bist_pass_o    = pass_q & bist_done_o;

`ifdef SRAM_BIST_FAIL_LOG_EN
   logic              fail_logged;
   logic [ADDR_W-1:0] cmp_addr;
`endif

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         elem        <= '0;
         addr        <= '0;
         second      <= 1'b0;
         pass_q      <= 1'b0;
         cmp_pend    <= 1'b0;
         cmp_exp     <= '0;
         bist_busy_o <= 1'b0;
         bist_done_o <= 1'b0;
`ifdef SRAM_BIST_FAIL_LOG_EN
         fail_logged <= 1'b0;
         cmp_addr    <= '0;
         fail_addr_o <= '0;
         fail_exp_o  <= '0;
         fail_got_o  <= '0;
`endif
      end else begin
         cmp_pend <= 1'b0;
         if (mismatch) begin
            pass_q <= 1'b0;
`ifdef SRAM_BIST_FAIL_LOG_EN
            if (!fail_logged) begin
               fail_logged <= 1'b1;
               fail_addr_o <= cmp_addr;
               fail_exp_o  <= cmp_exp;
               fail_got_o  <= bus.m_r_data_i;
            end
`endif
         end
         case (state)
            IDLE, DONE: begin
               if (bist_start_i) begin
                  state       <= RUN;
                  elem        <= '0;
                  addr        <= '0;
                  second      <= 1'b0;
                  pass_q      <= 1'b1;
                  bist_busy_o <= 1'b1;
                  bist_done_o <= 1'b0;
`ifdef SRAM_BIST_FAIL_LOG_EN
                  fail_logged <= 1'b0;
                  fail_addr_o <= '0;
                  fail_exp_o  <= '0;
                  fail_got_o  <= '0;
`endif
               end
            end
            RUN: begin
               if (op_read) begin
                  cmp_pend <= 1'b1;
                  cmp_exp  <= exp_data;
`ifdef SRAM_BIST_FAIL_LOG_EN
                  cmp_addr <= addr;
`endif
               end
               if (!op_last) begin
                  second <= 1'b1;
               end else begin
                  second <= 1'b0;
                  if (!addr_end) begin
                     addr <= desc ? addr - 1'b1 : addr + 1'b1;
                  end else if (elem == 3'd5) begin
                     state <= DRAIN;
                  end else begin
                     elem <= elem + 3'd1;
                     // M3 and M4 run downwards, so entering either starts at the top address.
                     addr <= (elem == 3'd2 || elem == 3'd3) ? ADDR_MAX : '0;
                  end
               end
            end
            DRAIN: begin
               state       <= DONE;
               bist_busy_o <= 1'b0;
               bist_done_o <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_sram_bist.sv
// Self-checking bench for sram_bist: SRAM model with injectable stuck-at fault and a
// March C- reference built from element rules; also builds with SRAM_BIST_FAIL_LOG_EN.
module tb_sram_bist;
   localparam int AW    = 8;
   localparam int DW    = 8;
   localparam int DEPTH = 1 << AW;

   typedef struct packed {
      logic          rd;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } op_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0;
   logic busy, done, pass;
   int   n_tests = 0;
   int   n_fail  = 0;

   sram_bist_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

`ifdef SRAM_BIST_FAIL_LOG_EN
   logic [AW-1:0] fail_addr;
   logic [DW-1:0] fail_exp, fail_got;
`endif

   sram_bist #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .bist_start_i (start),
      .bist_busy_o  (busy),
      .bist_done_o  (done),
      .bist_pass_o  (pass),
      .bus          (bus)
`ifdef SRAM_BIST_FAIL_LOG_EN
      ,
      .fail_addr_o  (fail_addr),
      .fail_exp_o   (fail_exp),
      .fail_got_o   (fail_got)
`endif
   );

   always #5 clk = ~clk;

   // SRAM wrapper model: one-cycle read latency, optional stuck-at bit on one address.
   bit [DW-1:0] mem [DEPTH];
   int          fault_addr = -1;
   bit [DW-1:0] fault_mask = '0;
   bit          fault_sa1  = 1'b0;

   function automatic bit [DW-1:0] faulty(bit [DW-1:0] v, int a);
      if (a != fault_addr) return v;
      return fault_sa1 ? (v | fault_mask) : (v & ~fault_mask);
   endfunction

   always @(posedge clk) begin
      if (bus.m_mem_en_o && bus.m_w_en_o) mem[bus.m_w_addr_o] <= bus.m_w_data_o;
      if (bus.m_mem_en_o && bus.m_r_en_o) bus.m_r_data_i <= faulty(mem[bus.m_r_addr_o], int'(bus.m_r_addr_o));
   end

   // Reference March C- operation list, built from the element table.
   op_t exp_ops[$];
   op_t got_ops[$];

   function automatic void add_elem(bit down, bit has_r, bit [DW-1:0] rv, bit has_w, bit [DW-1:0] wv);
      op_t o;
      for (int i = 0; i < DEPTH; i++) begin
         int a = down ? DEPTH - 1 - i : i;
         if (has_r) begin o.rd = 1'b1; o.addr = AW'(a); o.data = rv; exp_ops.push_back(o); end
         if (has_w) begin o.rd = 1'b0; o.addr = AW'(a); o.data = wv; exp_ops.push_back(o); end
      end
   endfunction

   function automatic void build_march();
      exp_ops.delete();
      add_elem(0, 0, 8'h00, 1, 8'h00);
      add_elem(0, 1, 8'h00, 1, 8'hFF);
      add_elem(0, 1, 8'hFF, 1, 8'h00);
      add_elem(1, 1, 8'h00, 1, 8'hFF);
      add_elem(1, 1, 8'hFF, 1, 8'h00);
      add_elem(0, 1, 8'h00, 0, 8'h00);
   endfunction

   bit          m_pass;
   bit [AW-1:0] m_faddr;
   bit [DW-1:0] m_fexp, m_fgot;

   function automatic void model_eval();
      bit [DW-1:0] m [DEPTH];
      bit [DW-1:0] got;
      m_pass = 1'b1; m_faddr = '0; m_fexp = '0; m_fgot = '0;
      foreach (exp_ops[i]) begin
         if (!exp_ops[i].rd) begin
            m[exp_ops[i].addr] = exp_ops[i].data;
         end else begin
            got = faulty(m[exp_ops[i].addr], int'(exp_ops[i].addr));
            if (got != exp_ops[i].data && m_pass) begin
               m_pass = 1'b0; m_faddr = exp_ops[i].addr; m_fexp = exp_ops[i].data; m_fgot = got;
            end
         end
      end
   endfunction

   // Observations of the most recent run (cycle 1 = period after the edge that samples start).
   int          busy_first, busy_last, done_cyc, addr_split;
   logic        pass_at_done;
   logic [AW-1:0] lg_addr;
   logic [DW-1:0] lg_exp, lg_got;
   logic [3*8-1:0] lg_start;

   task automatic run_march(input int poke_a, input int poke_b);
      op_t o;
      got_ops.delete();
      busy_first = 0; busy_last = 0; done_cyc = 0; addr_split = 0; pass_at_done = 1'bx;
      lg_addr = '0; lg_exp = '0; lg_got = '0; lg_start = '0;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      for (int cyc = 1; cyc <= 3000 && done_cyc == 0; cyc++) begin
         if (busy) begin
            if (busy_first == 0) busy_first = cyc;
            busy_last = cyc;
            if (bus.m_w_en_o || bus.m_r_en_o) begin
               o.rd   = bus.m_r_en_o;
               o.addr = bus.m_r_en_o ? bus.m_r_addr_o : bus.m_w_addr_o;
               o.data = bus.m_r_en_o ? '0 : bus.m_w_data_o;
               got_ops.push_back(o);
               if (bus.m_r_addr_o != bus.m_w_addr_o) addr_split++;
            end
         end
`ifdef SRAM_BIST_FAIL_LOG_EN
         if (cyc == 1) lg_start = {fail_addr, fail_exp, fail_got};
`endif
         if (done) begin
            done_cyc = cyc;
            pass_at_done = pass;
`ifdef SRAM_BIST_FAIL_LOG_EN
            lg_addr = fail_addr; lg_exp = fail_exp; lg_got = fail_got;
`endif
         end
         start = (cyc == poke_a) || (cyc == poke_b);
         @(negedge clk);
      end
      start = 1'b0;
   endtask

   task automatic drive_f_random();
      bus.f_mem_en_i = 1'($urandom); bus.f_w_en_i = 1'($urandom); bus.f_r_en_i = 1'($urandom);
      bus.f_w_addr_i = AW'($urandom); bus.f_r_addr_i = AW'($urandom); bus.f_w_data_i = DW'($urandom);
   endtask

   task automatic drive_f_idle();
      bus.f_mem_en_i = 1'b0; bus.f_w_en_i = 1'b0; bus.f_r_en_i = 1'b0;
      bus.f_w_addr_i = '0; bus.f_r_addr_i = '0; bus.f_w_data_i = '0;
   endtask

   task automatic test_reset();
      logic [2*AW+DW+2:0] f_v, m_v;
      drive_f_random();
      #1;
      f_v = {bus.f_mem_en_i, bus.f_w_en_i, bus.f_r_en_i, bus.f_w_addr_i, bus.f_r_addr_i, bus.f_w_data_i};
      m_v = {bus.m_mem_en_o, bus.m_w_en_o, bus.m_r_en_o, bus.m_w_addr_o, bus.m_r_addr_o, bus.m_w_data_o};
      n_tests++;
      if ({busy, done, pass} !== 3'b000) begin
         n_fail++; $display("FAIL reset_status: busy/done/pass=%b required 000", {busy, done, pass});
      end
      n_tests++;
      if (m_v !== f_v) begin
         n_fail++; $display("FAIL reset_mirror: m=%h required %h", m_v, f_v);
      end
      drive_f_idle();
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_passthrough();
      logic [2*AW+DW+2:0] f_v, m_v;
      int bad = 0;
      @(negedge clk);
      bus.f_mem_en_i = 1'b1; bus.f_w_en_i = 1'b1; bus.f_w_addr_i = 8'h10; bus.f_w_data_i = 8'hA5;
      @(negedge clk);
      bus.f_w_en_i = 1'b0; bus.f_r_en_i = 1'b1; bus.f_r_addr_i = 8'h10;
      @(negedge clk);
      n_tests++;
      if (bus.f_r_data_o !== 8'hA5) begin
         n_fail++; $display("FAIL passthru_read: got %h required a5", bus.f_r_data_o);
      end
      drive_f_idle();
      for (int i = 0; i < 16; i++) begin
         drive_f_random();
         #1;
         f_v = {bus.f_mem_en_i, bus.f_w_en_i, bus.f_r_en_i, bus.f_w_addr_i, bus.f_r_addr_i, bus.f_w_data_i};
         m_v = {bus.m_mem_en_o, bus.m_w_en_o, bus.m_r_en_o, bus.m_w_addr_o, bus.m_r_addr_o, bus.m_w_data_o};
         if (m_v !== f_v || {busy, done, pass} !== 3'b000) bad++;
         @(negedge clk);
      end
      drive_f_idle();
      n_tests++;
      if (bad !== 0) begin
         n_fail++; $display("FAIL passthru_mirror: %0d bad cycles required 0", bad);
      end
   endtask

   task automatic test_fault_free();
      int seq_bad = 0;
      fault_addr = -1;
      model_eval();
      drive_f_random();
      run_march(0, 0);
      drive_f_idle();
      n_tests++;
      if (busy_first !== 1 || busy_last !== 2561) begin
         n_fail++; $display("FAIL busy_window: cycles %0d..%0d required 1..2561", busy_first, busy_last);
      end
      n_tests++;
      if (done_cyc !== 2562) begin
         n_fail++; $display("FAIL done_cycle: got %0d required 2562", done_cyc);
      end
      n_tests++;
      if (pass_at_done !== m_pass) begin
         n_fail++; $display("FAIL fault_free_pass: got %b required %b", pass_at_done, m_pass);
      end
      if (got_ops.size() != exp_ops.size()) seq_bad = 1 + got_ops.size();
      else foreach (exp_ops[i])
         if (got_ops[i].rd != exp_ops[i].rd || got_ops[i].addr != exp_ops[i].addr ||
             (!exp_ops[i].rd && got_ops[i].data != exp_ops[i].data)) seq_bad++;
      n_tests++;
      if (seq_bad !== 0 || addr_split !== 0) begin
         n_fail++; $display("FAIL march_sequence: %0d bad ops, %0d split addrs, %0d ops required %0d",
                            seq_bad, addr_split, got_ops.size(), exp_ops.size());
      end
   endtask

   task automatic test_stuck_at();
      fault_addr = 8'h2A; fault_mask = 8'h08; fault_sa1 = 1'b1;
      run_march(0, 0);
      n_tests++;
      if (done_cyc !== 2562 || pass_at_done !== 1'b0) begin
         n_fail++; $display("FAIL sa1_result: done@%0d pass=%b required done@2562 pass=0", done_cyc, pass_at_done);
      end
`ifdef SRAM_BIST_FAIL_LOG_EN
      n_tests++;
      if ({lg_addr, lg_exp, lg_got} !== 24'h2A_00_08) begin
         n_fail++; $display("FAIL sa1_log: got %h required 2a0008", {lg_addr, lg_exp, lg_got});
      end
`endif
   endtask

   task automatic test_restart();
      fault_addr = -1;
      n_tests++;
      if (done !== 1'b1 || pass !== 1'b0) begin
         n_fail++; $display("FAIL pre_restart: done=%b pass=%b required 1 0", done, pass);
      end
      run_march(0, 0);
      n_tests++;
      if (done_cyc !== 2562 || pass_at_done !== 1'b1) begin
         n_fail++; $display("FAIL restart: done@%0d pass=%b required done@2562 pass=1", done_cyc, pass_at_done);
      end
`ifdef SRAM_BIST_FAIL_LOG_EN
      n_tests++;
      if (lg_start !== '0) begin
         n_fail++; $display("FAIL log_cleared_at_start: got %h required 0", lg_start);
      end
`endif
   endtask

   task automatic test_busy_starts();
      int late_bad = 0;
      run_march(5, 2561);
      n_tests++;
      if (done_cyc !== 2562 || busy_last !== 2561) begin
         n_fail++; $display("FAIL busy_start_ignored: done@%0d busy_last=%0d required 2562 2561", done_cyc, busy_last);
      end
      repeat (4) begin
         @(negedge clk);
         if (done !== 1'b1 || busy !== 1'b0 || pass !== 1'b1) late_bad++;
      end
      n_tests++;
      if (late_bad !== 0) begin
         n_fail++; $display("FAIL done_hold: %0d bad cycles required 0", late_bad);
      end
   endtask

   task automatic test_random_faults();
      for (int k = 0; k < 3; k++) begin
         fault_addr = int'($urandom_range(DEPTH - 1));
         fault_mask = DW'(1) << $urandom_range(DW - 1);
         fault_sa1  = 1'($urandom);
         model_eval();
         run_march(0, 0);
         n_tests++;
         if (done_cyc !== 2562 || pass_at_done !== m_pass) begin
            n_fail++; $display("FAIL rand_fault_%0d: done@%0d pass=%b required done@2562 pass=%b",
                               k, done_cyc, pass_at_done, m_pass);
         end
`ifdef SRAM_BIST_FAIL_LOG_EN
         n_tests++;
         if ({lg_addr, lg_exp, lg_got} !== {m_faddr, m_fexp, m_fgot}) begin
            n_fail++; $display("FAIL rand_log_%0d: got %h required %h", k, {lg_addr, lg_exp, lg_got},
                               {m_faddr, m_fexp, m_fgot});
         end
`endif
      end
      fault_addr = -1;
   endtask

   task automatic test_reset_mid_run();
      logic [2*AW+DW+2:0] f_v, m_v;
      int run_cyc = 0;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      for (int cyc = 1; cyc < 1000; cyc++) begin
         if (busy) run_cyc++;
         @(negedge clk);
      end
      drive_f_random();
      rst_n = 1'b0;
      #1;
      f_v = {bus.f_mem_en_i, bus.f_w_en_i, bus.f_r_en_i, bus.f_w_addr_i, bus.f_r_addr_i, bus.f_w_data_i};
      m_v = {bus.m_mem_en_o, bus.m_w_en_o, bus.m_r_en_o, bus.m_w_addr_o, bus.m_r_addr_o, bus.m_w_data_o};
      n_tests++;
      if ({busy, done, pass} !== 3'b000 || run_cyc !== 999) begin
         n_fail++; $display("FAIL mid_reset_status: busy/done/pass=%b run_cycles=%0d required 000 999",
                            {busy, done, pass}, run_cyc);
      end
      n_tests++;
      if (m_v !== f_v) begin
         n_fail++; $display("FAIL mid_reset_mirror: m=%h required %h", m_v, f_v);
      end
      @(negedge clk); rst_n = 1'b1; drive_f_idle();
      run_march(0, 0);
      n_tests++;
      if (done_cyc !== 2562 || pass_at_done !== 1'b1) begin
         n_fail++; $display("FAIL post_reset_run: done@%0d pass=%b required done@2562 pass=1", done_cyc, pass_at_done);
      end
   endtask

   initial begin
      build_march();
      test_reset();
      test_passthrough();
      test_fault_free();
      test_stuck_at();
      test_restart();
      test_busy_starts();
      test_random_faults();
      test_reset_mid_run();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
